nfc_page_copy: RTL and testbench

- Parametrised NAND-to-NAND page copy engine: reads pages from flash A and programs them into flash B at the same page address.
- Software-style start/busy/done control with a programmable start page and page count.
- Generalises the fixed 512x512 copier with configurable geometry, row-address cycles, ready/busy timeout and error reporting.
- Sits between the system controller and the two flash pin groups.

---
 rtl/nfc_page_copy.sv | 263 ++++++++++++++++++++++++++
 tb/tb_nfc_page_copy.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_page_copy.sv
// nfc_page_copy: reads pages from NAND flash A and programs them into flash B
// at the same page address. The controller issues start/start_page/page_count
// and watches busy/done/err.
// Optional build macro: NFC_STATUS_CHECK_EN adds a 0x70 status read after each
// program. Bit 0 of the status byte set means the program failed.
module nfc_page_copy #(
    parameter int PAGE_BYTES  = 512,
    parameter int PAGE_AW     = 9,
    parameter int ROW_CYCLES  = 2,
    parameter int TWB_CYC     = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PAGE_AW-1:0] start_page,
    input  logic [PAGE_AW:0]   page_count,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [PAGE_AW-1:0] err_page,
    inout  wire  [7:0]         F_IO_A,
    output logic               F_CLE_A,
    output logic               F_ALE_A,
    output logic               F_REN_A,
    output logic               F_WEN_A,
    input  logic               F_RB_A,
    inout  wire  [7:0]         F_IO_B,
    output logic               F_CLE_B,
    output logic               F_ALE_B,
    output logic               F_REN_B,
    output logic               F_WEN_B,
    input  logic               F_RB_B
);
    localparam int CNT_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PAGE_BYTES - 1);
    localparam logic [TMR_W-1:0]   TWB_LAST = TMR_W'(TWB_CYC - 1);
    localparam logic [TMR_W-1:0]   TO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]         IDX_LAST = 2'(ROW_CYCLES);
    localparam logic [PAGE_AW:0]   REM_ONE  = (PAGE_AW+1)'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_A_CMD, S_A_ADDR, S_A_WAIT, S_B_CMD, S_B_ADDR, S_XFER,
        S_B_PROG, S_B_WAIT,
`ifdef NFC_STATUS_CHECK_EN
        S_STATUS,
`endif
        S_NEXT, S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           ph_q, ph_d;        // sub-cycle within a strobe
    logic [1:0]           idx_q, idx_d;      // address byte index, 0 = column
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 twb_q, twb_d;      // tWB hold finished, RB now valid
    logic [PAGE_AW-1:0]   page_q, page_d;
    logic [PAGE_AW:0]     rem_q, rem_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [PAGE_AW-1:0]   epage_q, epage_d;
    logic [7:0]           data_q, data_d;
    logic                 io_a_oe, io_b_oe;
    logic [7:0]           io_a_val, io_b_val;
    logic                 accept, rb_sel, rb_ok, rb_to;

    // Column byte first, then the zero-extended page number LSB first
    function automatic logic [7:0] addr_byte(input logic [1:0] idx,
                                             input logic [PAGE_AW-1:0] pg);
        logic [23:0] row;
        row = 24'(pg);
        case (idx)
            2'd1:    addr_byte = row[7:0];
            2'd2:    addr_byte = row[15:8];
            2'd3:    addr_byte = row[23:16];
            default: addr_byte = 8'h00;
        endcase
    endfunction

    assign F_IO_A   = io_a_oe ? io_a_val : 8'bz;
    assign F_IO_B   = io_b_oe ? io_b_val : 8'bz;
    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done     = (state_q == S_FIN);
    assign err      = err_q;
    assign err_code = code_q;
    assign err_page = epage_q;

    // Control state; reset aborts any page in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            twb_q   <= 1'b0;
            page_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
            epage_q <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            twb_q   <= twb_d;
            page_q  <= page_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            code_q  <= code_d;
            epage_q <= epage_d;
        end
    end

    // Byte in transit from A to B (or status byte); no reset needed
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;  ph_d = ph_q;    idx_d = idx_q;   cnt_d = cnt_q;
        tmr_d   = tmr_q;    twb_d = twb_q;  page_d = page_q; rem_d = rem_q;
        err_d   = err_q;    code_d = code_q; epage_d = epage_q; data_d = data_q;
        F_CLE_A = 1'b0; F_ALE_A = 1'b0; F_WEN_A = 1'b1; F_REN_A = 1'b1;
        F_CLE_B = 1'b0; F_ALE_B = 1'b0; F_WEN_B = 1'b1; F_REN_B = 1'b1;
        io_a_oe = 1'b0; io_a_val = 8'h00; io_b_oe = 1'b0; io_b_val = 8'h00;
        accept  = start && ((state_q == S_IDLE) || (state_q == S_FIN));

        // Shared ready/busy timer: tWB hold first, then count RB-low samples
        rb_sel = (state_q == S_B_WAIT) ? F_RB_B : F_RB_A;
        rb_ok  = twb_q && rb_sel;
        rb_to  = twb_q && !rb_sel && (tmr_q == TO_LAST);
        if ((state_q == S_A_WAIT) || (state_q == S_B_WAIT)) begin
            if (!twb_q && (tmr_q == TWB_LAST)) begin
                twb_d = 1'b1;
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (accept) begin
                    err_d = 1'b0; code_d = 2'd0; epage_d = '0;
                    ph_d  = '0;   idx_d  = '0;   cnt_d   = '0;
                    if (page_count == '0) begin
                        state_d = S_FIN;
                    end else begin
                        page_d  = start_page;
                        rem_d   = page_count;
                        state_d = S_A_CMD;
                    end
                end
            end
            S_A_CMD: begin
                F_CLE_A = 1'b1; io_a_oe = 1'b1; io_a_val = 8'h00; F_WEN_A = ph_q[0];
                ph_d = {1'b0, ~ph_q[0]};
                if (ph_q[0]) begin idx_d = '0; state_d = S_A_ADDR; end
            end
            S_A_ADDR: begin
                F_ALE_A = 1'b1; io_a_oe = 1'b1; io_a_val = addr_byte(idx_q, page_q);
                F_WEN_A = ph_q[0];
                ph_d = {1'b0, ~ph_q[0]};
                if (ph_q[0]) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_A_WAIT; tmr_d = '0; twb_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_A_WAIT: begin
                if (rb_ok) begin
                    state_d = S_B_CMD; ph_d = '0;
                end else if (rb_to) begin
                    err_d = 1'b1; code_d = 2'd1; epage_d = page_q; state_d = S_FIN;
                end
            end
            S_B_CMD: begin
                F_CLE_B = 1'b1; io_b_oe = 1'b1; io_b_val = 8'h80; F_WEN_B = ph_q[0];
                ph_d = {1'b0, ~ph_q[0]};
                if (ph_q[0]) begin idx_d = '0; state_d = S_B_ADDR; end
            end
            S_B_ADDR: begin
                F_ALE_B = 1'b1; io_b_oe = 1'b1; io_b_val = addr_byte(idx_q, page_q);
                F_WEN_B = ph_q[0];
                ph_d = {1'b0, ~ph_q[0]};
                if (ph_q[0]) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_XFER; cnt_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_XFER: begin
                case (ph_q)
                    2'd0: begin
                        F_REN_A = 1'b0; data_d = F_IO_A; ph_d = 2'd1;
                    end
                    2'd1: begin
                        F_WEN_B = 1'b0; io_b_oe = 1'b1; io_b_val = data_q; ph_d = 2'd2;
                    end
                    default: begin
                        io_b_oe = 1'b1; io_b_val = data_q; ph_d = 2'd0;
                        if (cnt_q == CNT_LAST) state_d = S_B_PROG;
                        else                   cnt_d = cnt_q + 1'b1;
                    end
                endcase
            end
            S_B_PROG: begin
                F_CLE_B = 1'b1; io_b_oe = 1'b1; io_b_val = 8'h10; F_WEN_B = ph_q[0];
                ph_d = {1'b0, ~ph_q[0]};
                if (ph_q[0]) begin state_d = S_B_WAIT; tmr_d = '0; twb_d = 1'b0; end
            end
            S_B_WAIT: begin
                if (rb_ok) begin
`ifdef NFC_STATUS_CHECK_EN
                    state_d = S_STATUS; ph_d = '0;
`else
                    state_d = S_NEXT;
`endif
                end else if (rb_to) begin
                    err_d = 1'b1; code_d = 2'd2; epage_d = page_q; state_d = S_FIN;
                end
            end
`ifdef NFC_STATUS_CHECK_EN
            S_STATUS: begin
                ph_d = ph_q + 1'b1;
                case (ph_q)
                    2'd0, 2'd1: begin
                        F_CLE_B = 1'b1; io_b_oe = 1'b1; io_b_val = 8'h70; F_WEN_B = ph_q[0];
                    end
                    2'd2: begin
                        F_REN_B = 1'b0; data_d = F_IO_B;
                    end
                    default: begin
                        if (data_q[0]) begin
                            err_d = 1'b1; code_d = 2'd3; epage_d = page_q; state_d = S_FIN;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end
                endcase
            end
`endif
            S_NEXT: begin
                rem_d  = rem_q - 1'b1;
                page_d = page_q + 1'b1;
                ph_d   = '0;
                state_d = (rem_q == REM_ONE) ? S_FIN : S_A_CMD;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_nfc_page_copy.sv
// tb_nfc_page_copy: directed bench with behavioural models of both flashes.
// Flash A returns byte (i + page[7:0]) for read index i; flash B logs every
// latched byte as {CLE, ALE, IO}.
module tb_nfc_page_copy;
    localparam int PB = 512;
    localparam int AW = 9;
    localparam int TO = 300;
`ifdef NFC_STATUS_CHECK_EN
    localparam int PG_ENT = PB + 6;
`else
    localparam int PG_ENT = PB + 5;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_page = '0;
    logic [AW:0]   page_count = '0;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW-1:0] err_page;
    wire  [7:0]    F_IO_A, F_IO_B;
    logic          F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A, F_RB_A;
    logic          F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B, F_RB_B;

    nfc_page_copy #(.PAGE_BYTES(PB), .PAGE_AW(AW), .ROW_CYCLES(2), .TWB_CYC(2),
                    .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .start_page(start_page),
        .page_count(page_count), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .err_page(err_page),
        .F_IO_A(F_IO_A), .F_CLE_A(F_CLE_A), .F_ALE_A(F_ALE_A), .F_REN_A(F_REN_A),
        .F_WEN_A(F_WEN_A), .F_RB_A(F_RB_A),
        .F_IO_B(F_IO_B), .F_CLE_B(F_CLE_B), .F_ALE_B(F_ALE_B), .F_REN_B(F_REN_B),
        .F_WEN_B(F_WEN_B), .F_RB_B(F_RB_B));

    always #5 clk = ~clk;

    // Flash models
    logic [9:0]    a_log[$];
    logic [9:0]    b_log[$];
    int            a_addr_n = 0, b_addr_n = 0, rb_a_cnt = 0, rb_b_cnt = 0;
    logic [7:0]    a_row0 = 8'h00, b_row0 = 8'h00, a_rd = 8'h00;
    logic [AW-1:0] a_page = '0, b_page = '0;
    logic          wen_a_p = 1'b1, wen_b_p = 1'b1, ren_a_p = 1'b1, ren_b_p = 1'b1;
    int            done_cnt = 0, wa_fall = 0, wb_fall = 0, ra_fall = 0, rb_fall = 0;
    logic          stuck_en = 1'b0, fail_en = 1'b0;
    logic [AW-1:0] stuck_page = '0, fail_page = '0;

    assign F_IO_A = !F_REN_A ? (a_rd + a_page[7:0]) : 8'bz;
    assign F_IO_B = !F_REN_B ? ((fail_en && b_page == fail_page) ? 8'hE1 : 8'hE0) : 8'bz;
    assign F_RB_A = (rb_a_cnt == 0);
    assign F_RB_B = (rb_b_cnt == 0) && !(stuck_en && b_page == stuck_page);

    always @(negedge clk) begin
        wen_a_p <= F_WEN_A; wen_b_p <= F_WEN_B; ren_a_p <= F_REN_A; ren_b_p <= F_REN_B;
        if (done) done_cnt <= done_cnt + 1;
        if (!F_WEN_A && wen_a_p) wa_fall <= wa_fall + 1;
        if (!F_WEN_B && wen_b_p) wb_fall <= wb_fall + 1;
        if (!F_REN_A && ren_a_p) ra_fall <= ra_fall + 1;
        if (!F_REN_B && ren_b_p) rb_fall <= rb_fall + 1;
        if (rb_a_cnt != 0) rb_a_cnt <= rb_a_cnt - 1;
        if (rb_b_cnt != 0) rb_b_cnt <= rb_b_cnt - 1;
        if (F_REN_A && !ren_a_p) a_rd <= a_rd + 8'd1;
        if (F_WEN_A && !wen_a_p) begin
            a_log.push_back({F_CLE_A, F_ALE_A, F_IO_A});
            if (F_CLE_A) a_addr_n <= 0;
            else if (F_ALE_A) begin
                a_addr_n <= a_addr_n + 1;
                if (a_addr_n == 1) a_row0 <= F_IO_A;
                if (a_addr_n == 2) begin
                    a_page <= {F_IO_A[0], a_row0}; a_rd <= 8'h00; rb_a_cnt <= 4;
                end
            end
        end
        if (F_WEN_B && !wen_b_p) begin
            b_log.push_back({F_CLE_B, F_ALE_B, F_IO_B});
            if (F_CLE_B) begin
                b_addr_n <= 0;
                if (F_IO_B == 8'h10) rb_b_cnt <= 5;
            end else if (F_ALE_B) begin
                b_addr_n <= b_addr_n + 1;
                if (b_addr_n == 1) b_row0 <= F_IO_B;
                if (b_addr_n == 2) b_page <= {F_IO_B[0], b_row0};
            end
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [AW-1:0] pg, input logic [AW:0] cnt);
        @(negedge clk);
        start = 1'b1; start_page = pg; page_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(done), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic int cnt_cmd(input logic [9:0] q[$], input int base, input logic [7:0] op);
        int c;
        c = 0;
        for (int i = base; i < q.size(); i++)
            if (q[i] == {2'b10, op}) c++;
        return c;
    endfunction

    // One B page: 0x80, column, two row bytes, PB data bytes, 0x10 (+0x70)
    task automatic check_page(input string tag, input int base, input logic [7:0] r0,
                              input logic [7:0] r1);
        int mism;
        logic [7:0] exp;
        mism = 0;
        check_eq({tag, " hdr"}, {24'h0, b_log[base], b_log[base+1], b_log[base+2], b_log[base+3]},
                 {24'h0, 10'h280, 10'h100, {2'b01, r0}, {2'b01, r1}});
        for (int i = 0; i < PB; i++) begin
            exp = 8'(i) + r0;
            if (b_log[base+4+i] !== {2'b00, exp}) mism++;
        end
        check_eq({tag, " data"}, 64'(mism), 64'd0);
        check_eq({tag, " cmd10"}, 64'(b_log[base+4+PB]), 64'h210);
`ifdef NFC_STATUS_CHECK_EN
        check_eq({tag, " cmd70"}, 64'(b_log[base+5+PB]), 64'h270);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL global timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ab, bb, dc, tog;
        logic [AW-1:0] pgs [4];
        logic [7:0]    r0s [4];
        logic [7:0]    r1s [4];
        pgs = '{9'd510, 9'd511, 9'd0, 9'd1};
        r0s = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        r1s = '{8'h01, 8'h01, 8'h00, 8'h00};

        repeat (3) @(negedge clk);
        check_eq("rst strobes", 64'({F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A,
                                     F_CLE_B, F_ALE_B, F_WEN_B, F_REN_B}), 64'h33);
        check_eq("rst status", 64'({busy, done, err, err_code}), 64'd0);
        check_eq("rst err_page", 64'(err_page), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single page from page 0; a second start mid-copy must be ignored
        ab = a_log.size(); bb = b_log.size(); dc = done_cnt;
        start_op(9'd0, 10'd1);
        check_eq("t1 busy", 64'(busy), 64'd1);
        repeat (40) @(negedge clk);
        start_op(9'd9, 10'd3);
        wait_done("t1 done", 5000);
        check_eq("t1 done pulses", 64'(done_cnt - dc), 64'd1);
        check_eq("t1 err", 64'({err, err_code}), 64'd0);
        check_eq("t1 A seq", {24'h0, a_log[ab], a_log[ab+1], a_log[ab+2], a_log[ab+3]},
                 {24'h0, 10'h200, 10'h100, 10'h100, 10'h100});
        check_eq("t1 B len", 64'(b_log.size() - bb), 64'(PG_ENT));
        check_page("t1", bb, 8'h00, 8'h00);

        // Wrap from the last page back to page 0
        bb = b_log.size();
        start_op(9'd510, 10'd4);
        wait_done("t2 done", 20000);
        check_eq("t2 B len", 64'(b_log.size() - bb), 64'(4 * PG_ENT));
        for (int k = 0; k < 4; k++)
            check_page($sformatf("t2 page %0d", pgs[k]), bb + k * PG_ENT, r0s[k], r1s[k]);

        // Zero page count: immediate done, no flash activity
        tog = wa_fall + wb_fall + ra_fall + rb_fall;
        @(negedge clk);
        start = 1'b1; page_count = '0;
        @(negedge clk);
        start = 1'b0;
        check_eq("t3 done+busy", 64'({done, busy}), 64'h2);
        @(negedge clk);
        check_eq("t3 done drop", 64'(done), 64'd0);
        repeat (4) @(negedge clk);
        check_eq("t3 toggles", 64'(wa_fall + wb_fall + ra_fall + rb_fall - tog), 64'd0);

        // B stays busy after programming page 5 of 8
        stuck_en = 1'b1; stuck_page = 9'd5;
        ab = a_log.size(); bb = b_log.size();
        start_op(9'd0, 10'd8);
        wait_done("t4 done", 30000);
        check_eq("t4 err", 64'({err, err_code}), 64'h6);
        check_eq("t4 err_page", 64'(err_page), 64'd5);
        check_eq("t4 B pages", 64'(cnt_cmd(b_log, bb, 8'h80)), 64'd6);
        check_eq("t4 A pages", 64'(cnt_cmd(a_log, ab, 8'h00)), 64'd6);
        stuck_en = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t4 err sticky", 64'(err), 64'd1);

        // Reset during the data phase, then a clean copy
        bb = b_log.size();
        start_op(9'd3, 10'd1);
        check_eq("t5 err cleared", 64'({err, err_code}), 64'd0);
        for (int n = 0; n < 5000 && (b_log.size() - bb) < 104; n++) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check_eq("t5 async strobes", 64'({F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A,
                                          F_CLE_B, F_ALE_B, F_WEN_B, F_REN_B}), 64'h33);
        check_eq("t5 async busy", 64'({busy, done}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bb = b_log.size();
        start_op(9'd7, 10'd1);
        wait_done("t5 done", 5000);
        check_eq("t5 B len", 64'(b_log.size() - bb), 64'(PG_ENT));
        check_page("t5", bb, 8'h07, 8'h00);

        // Program status failure on page 2
        fail_en = 1'b1; fail_page = 9'd2;
        bb = b_log.size();
        start_op(9'd0, 10'd4);
        wait_done("t6 done", 20000);
`ifdef NFC_STATUS_CHECK_EN
        check_eq("t6 err", 64'({err, err_code}), 64'h7);
        check_eq("t6 err_page", 64'(err_page), 64'd2);
        check_eq("t6 B pages", 64'(cnt_cmd(b_log, bb, 8'h80)), 64'd3);
`else
        check_eq("t6 err", 64'({err, err_code}), 64'd0);
        check_eq("t6 no status cmd", 64'(cnt_cmd(b_log, bb, 8'h70)), 64'd0);
        check_eq("t6 B pages", 64'(cnt_cmd(b_log, bb, 8'h80)), 64'd4);
`endif
        fail_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
